// File: rtl/sw_stim_driver.sv
// Automated switch-bus operator for the complex-multiplier top level: enters four
// operand words with the reset/handshake protocol, then captures both LED results.
module sw_stim_driver #(
   parameter int WORD_W     = 8,
   parameter int RST_CYC    = 4,
   parameter int SETUP_CYC  = 2,
   parameter int HOLD_CYC   = 4,
   parameter int GAP_CYC    = 4,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] re_a,
   input  logic [WORD_W-1:0] im_a,
   input  logic [WORD_W-1:0] re_q,
   input  logic [WORD_W-1:0] im_q,
   input  logic [WORD_W-1:0] led_in,
   output logic [WORD_W+1:0] sw_out,
   output logic [WORD_W-1:0] re_res,
   output logic [WORD_W-1:0] im_res,
   output logic              busy,
   output logic              done
);

   localparam int MAX_A   = (RST_CYC > SETUP_CYC) ? RST_CYC : SETUP_CYC;
   localparam int MAX_B   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_CYC = (MAX_C > SETTLE_CYC) ? MAX_C : SETTLE_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DUT_RST = 3'd1;
   localparam logic [2:0] ST_SETUP   = 3'd2;
   localparam logic [2:0] ST_HS_HIGH = 3'd3;
   localparam logic [2:0] ST_HS_LOW  = 3'd4;
   localparam logic [2:0] ST_DISP_RE = 3'd5;
   localparam logic [2:0] ST_DISP_IM = 3'd6;
   localparam logic [2:0] ST_FINISH  = 3'd7;

   logic [2:0]        state_r, state_s;
   logic [1:0]        idx_r, idx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [WORD_W-1:0] re_a_r, im_a_r, re_q_r, im_q_r;
   logic [WORD_W-1:0] re_res_r, im_res_r, word_s;
   logic [WORD_W+1:0] sw_r, sw_s;
   logic              busy_r, done_r, busy_s, done_s;
   logic              load_s, cap_re_s, cap_im_s;

   // Next-state, word index and per-phase down-counter; counter reloads on every state entry
   always_comb begin
      state_s  = state_r;
      idx_s    = idx_r;
      cnt_s    = cnt_r;
      load_s   = 1'b0;
      cap_re_s = 1'b0;
      cap_im_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_DUT_RST;
               cnt_s   = RST_LD;
               idx_s   = 2'd0;
               load_s  = 1'b1;
            end else begin
               cnt_s   = CNT_ZERO;
            end
         end
         ST_DUT_RST: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_SETUP;
               cnt_s   = SETUP_LD;
            end else begin
               cnt_s   = cnt_r - CNT_W'(1'b1);
            end
         end
         ST_SETUP: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_HS_HIGH;
               cnt_s   = HOLD_LD;
            end else begin
               cnt_s   = cnt_r - CNT_W'(1'b1);
            end
         end
         ST_HS_HIGH: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_HS_LOW;
               cnt_s   = GAP_LD;
            end else begin
               cnt_s   = cnt_r - CNT_W'(1'b1);
            end
         end
         ST_HS_LOW: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_s   = cnt_r - CNT_W'(1'b1);
            end else if (idx_r == 2'd3) begin
               state_s = ST_DISP_RE;
               cnt_s   = SETTLE_LD;
            end else begin
               state_s = ST_SETUP;
               idx_s   = idx_r + 2'd1;
               cnt_s   = SETUP_LD;
            end
         end
         ST_DISP_RE: begin
            if (cnt_r == CNT_ZERO) begin
               state_s  = ST_DISP_IM;
               cnt_s    = SETTLE_LD;
               cap_re_s = 1'b1;
            end else begin
               cnt_s    = cnt_r - CNT_W'(1'b1);
            end
         end
         ST_DISP_IM: begin
            if (cnt_r == CNT_ZERO) begin
               state_s  = ST_FINISH;
               cnt_s    = CNT_ZERO;
               cap_im_s = 1'b1;
            end else begin
               cnt_s    = cnt_r - CNT_W'(1'b1);
            end
         end
         ST_FINISH: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
         end
         default: begin
            state_s = ST_IDLE;
            idx_s   = 2'd0;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Output decode from the next state so registered outputs line up with the state register
   always_comb begin
      case (idx_s)
         2'd0:    word_s = re_a_r;
         2'd1:    word_s = im_a_r;
         2'd2:    word_s = re_q_r;
         default: word_s = im_q_r;
      endcase
      busy_s = (state_s != ST_IDLE);
      done_s = (state_s == ST_FINISH);
      case (state_s)
         ST_DUT_RST: sw_s = {1'b0, 1'b0, {WORD_W{1'b0}}};
         ST_SETUP:   sw_s = {1'b1, 1'b0, word_s};
         ST_HS_HIGH: sw_s = {1'b1, 1'b1, word_s};
         ST_HS_LOW:  sw_s = {1'b1, 1'b0, word_s};
         ST_DISP_IM: sw_s = {1'b1, 1'b1, {WORD_W{1'b0}}};
         default:    sw_s = {1'b1, 1'b0, {WORD_W{1'b0}}};
      endcase
   end

   // State, operand latches, result captures and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_IDLE;
         idx_r    <= 2'd0;
         cnt_r    <= CNT_ZERO;
         re_a_r   <= {WORD_W{1'b0}};
         im_a_r   <= {WORD_W{1'b0}};
         re_q_r   <= {WORD_W{1'b0}};
         im_q_r   <= {WORD_W{1'b0}};
         re_res_r <= {WORD_W{1'b0}};
         im_res_r <= {WORD_W{1'b0}};
         sw_r     <= {1'b1, 1'b0, {WORD_W{1'b0}}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
         sw_r    <= sw_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         if (load_s) begin
            re_a_r <= re_a;
            im_a_r <= im_a;
            re_q_r <= re_q;
            im_q_r <= im_q;
         end
         if (cap_re_s) begin
            re_res_r <= led_in;
         end
         if (cap_im_s) begin
            im_res_r <= led_in;
         end
      end
   end

   assign sw_out = sw_r;
   assign re_res = re_res_r;
   assign im_res = im_res_r;
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: tb/tb_sw_stim_driver.sv
// Directed self-checking bench for sw_stim_driver: default and all-ones timing
// instances, protocol monitoring, mid-sequence reset and back-to-back starts.
module tb_sw_stim_driver;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, start0, start1;
   logic [W-1:0] re_a, im_a, re_q, im_q, led;
   logic [W+1:0] sw0, sw1;
   logic [W-1:0] rr0, ir0, rr1, ir1;
   logic         busy0, busy1, done0, done1;
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   sw_stim_driver dut0 (
      .clk(clk), .reset(reset), .start(start0),
      .re_a(re_a), .im_a(im_a), .re_q(re_q), .im_q(im_q), .led_in(led),
      .sw_out(sw0), .re_res(rr0), .im_res(ir0), .busy(busy0), .done(done0)
   );

   sw_stim_driver #(
      .WORD_W(8), .RST_CYC(1), .SETUP_CYC(1), .HOLD_CYC(1), .GAP_CYC(1), .SETTLE_CYC(1)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start1),
      .re_a(re_a), .im_a(im_a), .re_q(re_q), .im_q(im_q), .led_in(led),
      .sw_out(sw1), .re_res(rr1), .im_res(ir1), .busy(busy1), .done(done1)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full sequence on dut0 (sel=0) or dut1 (sel=1); e counts edges, e=1 is the accepting edge
   task automatic run_seq(input string nm, input bit sel, input int rc, input int sc,
                          input int hc, input int gc, input int tc,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d,
                          input logic [W-1:0] lre, input logic [W-1:0] lim, input bit scramble);
      int           wl;
      int           last;
      int           pulses, hs_len, len_err, stab_err, rst_low, rst_err;
      int           done_cnt, done_err, busy_err;
      logic         prev_hs, bz, dn;
      logic [W-1:0] prev_data, hs_data, rr, ir;
      logic [W+1:0] sw;
      logic [W-1:0] exp_w [4];
      wl   = sc + hc + gc;
      last = 1 + rc + 4 * wl + 2 * tc;
      pulses = 0; hs_len = 0; len_err = 0; stab_err = 0; rst_low = 0; rst_err = 0;
      done_cnt = 0; done_err = 0; busy_err = 0;
      prev_hs = 1'b0; prev_data = 8'h00; hs_data = 8'h00;
      bz = 1'b0; dn = 1'b0; rr = 8'h00; ir = 8'h00; sw = 10'h000;
      exp_w[0] = a; exp_w[1] = b; exp_w[2] = c; exp_w[3] = d;
      re_a = a; im_a = b; re_q = c; im_q = d; led = 8'h77;
      if (sel) start1 = 1'b1;
      else     start0 = 1'b1;
      for (int e = 1; e <= last + 1; e++) begin
         tick();
         start0 = 1'b0;
         start1 = 1'b0;
         if (scramble) begin
            re_a = ~a; im_a = ~b; re_q = ~c; im_q = ~d;
         end
         led = (e == rc + 4 * wl + tc) ? lre : ((e == last - 1) ? lim : 8'h77);
         sw = sel ? sw1 : sw0;
         bz = sel ? busy1 : busy0;
         dn = sel ? done1 : done0;
         rr = sel ? rr1 : rr0;
         ir = sel ? ir1 : ir0;
         if (sw[W+1] == 1'b0) begin
            rst_low++;
            if (e > rc) rst_err++;
         end
         if (sw[W] && !prev_hs) begin
            pulses++;
            hs_len  = 1;
            hs_data = sw[W-1:0];
         end else if (sw[W]) begin
            hs_len++;
            if (sw[W-1:0] != hs_data) stab_err++;
         end else if (prev_hs) begin
            if (hs_len != ((pulses <= 4) ? hc : tc)) len_err++;
         end
         if ((sw[W] != prev_hs) && (sw[W-1:0] != prev_data)) stab_err++;
         prev_hs   = sw[W];
         prev_data = sw[W-1:0];
         for (int w = 0; w < 4; w++) begin
            if (e == rc + 1 + w * wl) check_eq({nm, " setup_word"}, 32'(sw), 32'({2'b10, exp_w[w]}));
         end
         if (dn) begin
            done_cnt++;
            if (e != last) done_err++;
         end
         if (!bz && e <= last) busy_err++;
      end
      check_eq({nm, " hs_pulses"}, pulses, 32'd5);
      check_eq({nm, " hs_len_err"}, len_err, 32'd0);
      check_eq({nm, " data_stable_err"}, stab_err, 32'd0);
      check_eq({nm, " rstn_low_cycles"}, rst_low, rc);
      check_eq({nm, " rstn_low_pos_err"}, rst_err, 32'd0);
      check_eq({nm, " done_count"}, done_cnt, 32'd1);
      check_eq({nm, " done_timing_err"}, done_err, 32'd0);
      check_eq({nm, " busy_err"}, busy_err, 32'd0);
      check_eq({nm, " busy_after"}, 32'(bz), 32'd0);
      check_eq({nm, " re_res"}, 32'(rr), 32'(lre));
      check_eq({nm, " im_res"}, 32'(ir), 32'(lim));
   endtask

   int   b_done, b_first, b_last, b_gap_err, b_wide_err, b_busy_low, b_restart_err;
   logic b_prev_d, b_prev_b;

   initial begin
      reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
      re_a = 8'h00; im_a = 8'h00; re_q = 8'h00; im_q = 8'h00; led = 8'h00;
      repeat (3) tick();
      reset = 1'b0;
      check_eq("reset sw_out", 32'(sw0), 32'h200);
      check_eq("reset busy", 32'(busy0), 32'd0);
      check_eq("reset done", 32'(done0), 32'd0);
      check_eq("reset re_res", 32'(rr0), 32'd0);
      check_eq("reset im_res", 32'(ir0), 32'd0);

      // (3+2j)(1+4j) = -5+14j shown on the LEDs as FB / 0E
      run_seq("cmul", 1'b0, 4, 2, 4, 4, 4, 8'h03, 8'h02, 8'h01, 8'h04, 8'hFB, 8'h0E, 1'b1);
      run_seq("leds", 1'b0, 4, 2, 4, 4, 4, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 1'b0);

      // Reset during HS_HIGH of word 2 (edge 28 of the sequence)
      re_a = 8'h61; im_a = 8'h62; re_q = 8'h63; im_q = 8'h64;
      start0 = 1'b1;
      for (int e = 1; e <= 28; e++) begin
         tick();
         start0 = 1'b0;
      end
      check_eq("pre_rst hs_word2", 32'(sw0), 32'h363);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("mid_rst sw_out", 32'(sw0), 32'h200);
      check_eq("mid_rst busy", 32'(busy0), 32'd0);
      check_eq("mid_rst done", 32'(done0), 32'd0);
      check_eq("mid_rst re_res", 32'(rr0), 32'd0);
      check_eq("mid_rst im_res", 32'(ir0), 32'd0);
      run_seq("after_rst", 1'b0, 4, 2, 4, 4, 4, 8'h80, 8'h7F, 8'hC0, 8'h01, 8'h3C, 8'hC3, 1'b0);

      run_seq("fast", 1'b1, 1, 1, 1, 1, 1, 8'h9A, 8'h0B, 8'hE1, 8'h55, 8'hC3, 8'h3C, 1'b1);

      // start held high: sequences of 54 cycles, done on 53, 107, 161
      b_done = 0; b_first = 0; b_last = 0; b_gap_err = 0; b_wide_err = 0;
      b_busy_low = 0; b_restart_err = 0; b_prev_d = 1'b0; b_prev_b = 1'b1;
      led = 8'h77;
      start0 = 1'b1;
      for (int e = 1; e <= 200; e++) begin
         tick();
         if (done0) begin
            b_done++;
            if (b_prev_d) b_wide_err++;
            if (b_done == 1) b_first = e;
            else if (e - b_last != 54) b_gap_err++;
            b_last = e;
         end
         if (!busy0) begin
            b_busy_low++;
            if (!b_prev_b) b_restart_err++;
         end
         b_prev_d = done0;
         b_prev_b = busy0;
      end
      start0 = 1'b0;
      check_eq("b2b done_count", b_done, 32'd3);
      check_eq("b2b first_done", b_first, 32'd53);
      check_eq("b2b gap_err", b_gap_err, 32'd0);
      check_eq("b2b wide_err", b_wide_err, 32'd0);
      check_eq("b2b idle_cycles", b_busy_low, 32'd3);
      check_eq("b2b restart_err", b_restart_err, 32'd0);
      repeat (60) tick();
      check_eq("b2b final_busy", 32'(busy0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
